// File: rtl/cpu_pipe_ctrl.sv
// Five-stage pipeline controller: counted register scoreboard, jump/branch wait FSM, memory freeze.
// Optional stall-cycle counters are built when CPU_STALL_CNT_EN is defined.
module cpu_pipe_ctrl #(
    parameter int unsigned NREG = 16,
`ifdef CPU_STALL_CNT_EN
    parameter int unsigned CNT_W = 32,
`endif
    localparam int unsigned RW = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dec_valid,
    input  logic [RW-1:0] dec_rs1,
    input  logic [RW-1:0] dec_rs2,
    input  logic          dec_rs1_en,
    input  logic          dec_rs2_en,
    input  logic [RW-1:0] dec_wrt_reg,
    input  logic          dec_wrt_en,
    input  logic          dec_is_jb,
    input  logic          exec_jb_resolve,
    input  logic          exec_jb_taken,
    input  logic [RW-1:0] wb_wrt_reg,
    input  logic          wb_wrt_en,
    input  logic          mem_busy,
    output logic          if_en,
    output logic          dec_en,
    output logic          exec_en,
    output logic          mem_en,
    output logic          wb_en,
    output logic          dec_bubble,
    output logic          if_flush,
    output logic          rd_wrt_stall,
    output logic          jb_stall,
    output logic          sb_err
`ifdef CPU_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] rd_stall_cnt,
    output logic [CNT_W-1:0] jb_stall_cnt,
    output logic [CNT_W-1:0] mem_stall_cnt
`endif
);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_JB_WAIT = 1'b1;

    logic [1:0]      cnt_q [NREG];
    logic [1:0]      cnt_d [NREG];
    logic [0:0]      state_q, state_d;
    logic            sb_err_q, sb_err_d;
    logic [NREG-1:0] inc_vec, dec_vec;
    logic            in_idle, retire, issue, hazard, rs1_haz, rs2_haz;
    logic            jb_stall_c, rd_stall_c;

    // A source retiring from WB this cycle with a single pending write is
    // already visible through the write-through register file.
    always_comb begin
        in_idle = (state_q == ST_IDLE);
        retire  = wb_wrt_en & ~mem_busy;
        rs1_haz = dec_rs1_en && (cnt_q[dec_rs1] != 2'd0) &&
                  !(retire && (dec_rs1 == wb_wrt_reg) && (cnt_q[dec_rs1] == 2'd1));
        rs2_haz = dec_rs2_en && (cnt_q[dec_rs2] != 2'd0) &&
                  !(retire && (dec_rs2 == wb_wrt_reg) && (cnt_q[dec_rs2] == 2'd1));
        hazard     = rs1_haz | rs2_haz;
        issue      = dec_valid & ~mem_busy & in_idle & ~hazard;
        jb_stall_c = ~in_idle & ~mem_busy;
        rd_stall_c = hazard & in_idle & dec_valid & ~mem_busy;
    end

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (issue && dec_wrt_en) inc_vec[dec_wrt_reg] = 1'b1;
        if (retire) dec_vec[wb_wrt_reg] = 1'b1;
        cnt_d    = cnt_q;
        sb_err_d = sb_err_q;
        for (int i = 0; i < NREG; i++) begin
            case ({inc_vec[i], dec_vec[i]})
                2'b10: begin
                    if (cnt_q[i] == 2'd3) sb_err_d = 1'b1;
                    else cnt_d[i] = cnt_q[i] + 2'd1;
                end
                2'b01: begin
                    if (cnt_q[i] == 2'd0) sb_err_d = 1'b1;
                    else cnt_d[i] = cnt_q[i] - 2'd1;
                end
                default: ;
            endcase
        end
    end

    // The resolve pulse is honoured even while memory freezes the pipeline.
    always_comb begin
        state_d = state_q;
        if (state_q == ST_IDLE) begin
            if (issue && dec_is_jb) state_d = ST_JB_WAIT;
        end else if (exec_jb_resolve) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) cnt_q[i] <= 2'd0;
            state_q  <= ST_IDLE;
            sb_err_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            sb_err_q <= sb_err_d;
        end
    end

    always_comb begin
        if_en      = 1'b1;
        dec_en     = 1'b1;
        exec_en    = 1'b1;
        mem_en     = 1'b1;
        wb_en      = 1'b1;
        dec_bubble = 1'b0;
        if (!rst) begin
            if (mem_busy) begin
                if_en   = 1'b0;
                dec_en  = 1'b0;
                exec_en = 1'b0;
                mem_en  = 1'b0;
                wb_en   = 1'b0;
            end else if (jb_stall_c || rd_stall_c) begin
                if_en      = 1'b0;
                dec_en     = 1'b0;
                dec_bubble = 1'b1;
            end
        end
        if_flush     = ~rst & exec_jb_resolve & exec_jb_taken & ~in_idle;
        rd_wrt_stall = ~rst & rd_stall_c;
        jb_stall     = ~rst & jb_stall_c;
        sb_err       = ~rst & sb_err_q;
    end

`ifdef CPU_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_stall_cnt  <= '0;
            jb_stall_cnt  <= '0;
            mem_stall_cnt <= '0;
        end else begin
            if (rd_stall_c) rd_stall_cnt <= rd_stall_cnt + 1'b1;
            if (jb_stall_c) jb_stall_cnt <= jb_stall_cnt + 1'b1;
            if (mem_busy) mem_stall_cnt <= mem_stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_pipe_ctrl.sv
// Directed bench for cpu_pipe_ctrl: per-cycle expected output vectors queued at drive time,
// popped and compared at the following falling edge.
module tb_cpu_pipe_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       dec_valid, dec_rs1_en, dec_rs2_en, dec_wrt_en, dec_is_jb;
    logic [3:0] dec_rs1, dec_rs2, dec_wrt_reg, wb_wrt_reg;
    logic       exec_jb_resolve, exec_jb_taken, wb_wrt_en, mem_busy;
    logic       if_en, dec_en, exec_en, mem_en, wb_en;
    logic       dec_bubble, if_flush, rd_wrt_stall, jb_stall, sb_err;
`ifdef CPU_STALL_CNT_EN
    logic [31:0] rd_stall_cnt, jb_stall_cnt, mem_stall_cnt;
`endif

    always #5 clk = ~clk;

    cpu_pipe_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .dec_valid       (dec_valid),
        .dec_rs1         (dec_rs1),
        .dec_rs2         (dec_rs2),
        .dec_rs1_en      (dec_rs1_en),
        .dec_rs2_en      (dec_rs2_en),
        .dec_wrt_reg     (dec_wrt_reg),
        .dec_wrt_en      (dec_wrt_en),
        .dec_is_jb       (dec_is_jb),
        .exec_jb_resolve (exec_jb_resolve),
        .exec_jb_taken   (exec_jb_taken),
        .wb_wrt_reg      (wb_wrt_reg),
        .wb_wrt_en       (wb_wrt_en),
        .mem_busy        (mem_busy),
        .if_en           (if_en),
        .dec_en          (dec_en),
        .exec_en         (exec_en),
        .mem_en          (mem_en),
        .wb_en           (wb_en),
        .dec_bubble      (dec_bubble),
        .if_flush        (if_flush),
        .rd_wrt_stall    (rd_wrt_stall),
        .jb_stall        (jb_stall),
        .sb_err          (sb_err)
`ifdef CPU_STALL_CNT_EN
        ,
        .rd_stall_cnt    (rd_stall_cnt),
        .jb_stall_cnt    (jb_stall_cnt),
        .mem_stall_cnt   (mem_stall_cnt)
`endif
    );

    // {if_en, dec_en, exec_en, mem_en, wb_en, dec_bubble, if_flush, rd_wrt_stall, jb_stall}
    localparam logic [8:0] P_RUN  = 9'b11111_0_0_0_0;
    localparam logic [8:0] P_RD   = 9'b00111_1_0_1_0;
    localparam logic [8:0] P_JB   = 9'b00111_1_0_0_1;
    localparam logic [8:0] P_JBF  = 9'b00111_1_1_0_1;
    localparam logic [8:0] P_FRZ  = 9'b00000_0_0_0_0;
    localparam logic [8:0] P_FRZF = 9'b00000_0_1_0_0;

    typedef struct {
        string      tag;
        logic [9:0] exp;
    } exp_t;

    exp_t       sb_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    logic       err_exp  = 1'b0;
    logic [9:0] obs;

    assign obs = {if_en, dec_en, exec_en, mem_en, wb_en,
                  dec_bubble, if_flush, rd_wrt_stall, jb_stall, sb_err};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr_in();
        rst = 1'b0; dec_valid = 1'b0; dec_rs1 = '0; dec_rs2 = '0;
        dec_rs1_en = 1'b0; dec_rs2_en = 1'b0; dec_wrt_reg = '0; dec_wrt_en = 1'b0;
        dec_is_jb = 1'b0; exec_jb_resolve = 1'b0; exec_jb_taken = 1'b0;
        wb_wrt_reg = '0; wb_wrt_en = 1'b0; mem_busy = 1'b0;
    endtask

    task automatic wr(input logic [3:0] r);
        dec_valid = 1'b1; dec_wrt_reg = r; dec_wrt_en = 1'b1;
    endtask

    task automatic rd1(input logic [3:0] r);
        dec_valid = 1'b1; dec_rs1 = r; dec_rs1_en = 1'b1;
    endtask

    task automatic rd2(input logic [3:0] r);
        dec_valid = 1'b1; dec_rs2 = r; dec_rs2_en = 1'b1;
    endtask

    task automatic ret(input logic [3:0] r);
        wb_wrt_reg = r; wb_wrt_en = 1'b1;
    endtask

    task automatic jb();
        dec_valid = 1'b1; dec_is_jb = 1'b1;
    endtask

    task automatic res(input logic taken);
        exec_jb_resolve = 1'b1; exec_jb_taken = taken;
    endtask

    // Inputs are already driven for this cycle; queue the expectation, compare mid-cycle.
    task automatic tick(input string tag, input logic [8:0] pat);
        exp_t e;
        e.tag = tag;
        e.exp = {pat, err_exp};
        sb_q.push_back(e);
        @(negedge clk);
        e = sb_q.pop_front();
        check_val(e.tag, 32'(obs), 32'(e.exp));
        @(posedge clk);
        #1;
        clr_in();
    endtask

    initial begin
        clr_in();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick("reset", P_RUN);

        // Back-to-back hazard on r5, resolved by the write-through retire.
        wr(5);          tick("t1_prod", P_RUN);
        rd1(5);         tick("t1_stall1", P_RD);
        rd1(5);         tick("t1_stall2", P_RD);
        rd1(5); ret(5); tick("t1_bypass", P_RUN);
        rd1(5);         tick("t1_cnt0", P_RUN);

        // Three writes in flight, then an overflowing fourth.
        repeat (3) begin
            wr(3); tick("t2_wr", P_RUN);
        end
        rd1(3);         tick("t2_full", P_RD);
        wr(3);          tick("t2_ovf", P_RUN);
        err_exp = 1'b1;
        ret(3);         tick("t2_sticky", P_RUN);
                        tick("t2_sticky2", P_RUN);
        rst = 1'b1; err_exp = 1'b0;
                        tick("t2_rst", P_RUN);
        rd1(3);         tick("t2_clr", P_RUN);

        // Taken and not-taken branch resolution, stray resolve in IDLE.
        jb();                       tick("t3_issue", P_RUN);
        dec_valid = 1'b1;           tick("t3_wait", P_JB);
        dec_valid = 1'b1; res(1'b1); tick("t3_flush", P_JBF);
        dec_valid = 1'b1;           tick("t3_idle", P_RUN);
        jb();                       tick("t3_issue_nt", P_RUN);
        dec_valid = 1'b1;           tick("t3_wait_nt", P_JB);
        dec_valid = 1'b1; res(1'b0); tick("t3_noflush", P_JB);
        dec_valid = 1'b1;           tick("t3_idle_nt", P_RUN);
        dec_valid = 1'b1; res(1'b1); tick("t3_ign", P_RUN);
        dec_valid = 1'b1;           tick("t3_ign2", P_RUN);

        // Memory freeze during an r7 hazard.
        wr(7);                           tick("t4_prod", P_RUN);
        dec_valid = 1'b1; dec_rs1 = 4'd7; tick("t4_noen", P_RUN);
        rd1(7);                          tick("t4_haz", P_RD);
        dec_rs2 = 4'd7; dec_rs2_en = 1'b1; tick("t4_novalid", P_RUN);
        repeat (4) begin
            rd1(7); mem_busy = 1'b1; tick("t4_frz", P_FRZ);
        end
        rd1(7);         tick("t4_resume", P_RD);
        rd1(7); ret(7); tick("t4_ret", P_RUN);
        rd1(7);         tick("t4_cnt0", P_RUN);
        jb();                           tick("t4_jb", P_RUN);
        mem_busy = 1'b1; res(1'b1);     tick("t4_frz_res", P_FRZF);
        dec_valid = 1'b1;               tick("t4_post", P_RUN);

        // Simultaneous issue and retire.
        wr(9);          tick("t5_prod", P_RUN);
        wr(9); ret(9);  tick("t5_both", P_RUN);
        rd1(9); ret(9); tick("t5_bypass", P_RUN);
        rd1(9);         tick("t5_zero", P_RUN);
        wr(2);          tick("t5_r2_prod", P_RUN);
                        tick("t5_r2_gap", P_RUN);
        rd2(2); ret(2); tick("t5_r2", P_RUN);
        rd2(2);         tick("t5_r2_zero", P_RUN);

        // Reset while waiting on a branch with r4 pending twice.
        wr(4);                      tick("t6_w1", P_RUN);
        wr(4);                      tick("t6_w2", P_RUN);
        jb();                       tick("t6_jb", P_RUN);
        dec_valid = 1'b1;           tick("t6_wait", P_JB);
        rst = 1'b1; dec_valid = 1'b1; tick("t6_rst", P_RUN);
        rd1(4);                     tick("t6_idle", P_RUN);
        rd1(4);                     tick("t6_cnt0", P_RUN);

        wr(6); tick("t7_prod", P_RUN);
        repeat (5) begin
            rd1(6); tick("t7_stall", P_RD);
        end
        rd1(6); ret(6); tick("t7_ret", P_RUN);
`ifdef CPU_STALL_CNT_EN
        check_val("rd_stall_cnt", rd_stall_cnt, 32'd5);
        check_val("jb_stall_cnt", jb_stall_cnt, 32'd0);
        check_val("mem_stall_cnt", mem_stall_cnt, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
